// File: rtl/led_frame_scheduler.sv
// Pixel transmit sequencer for the 8x8 LED matrix: fetch/load/send per pixel, latch gap,
// minimum frame period and frame-boundary bank swap. Optional SEND watchdog: LED_TX_TIMEOUT_EN.
module led_frame_scheduler #(
   parameter int NUM_PIXELS     = 64,
   parameter int PIXEL_W        = 6,
   parameter int FRAME_W        = 5,
   parameter int LATCH_CYCLES   = 3600,
   parameter int FRAME_PERIOD   = 400000,
   parameter int TIMEOUT_CYCLES = 512
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic               swap_req,
   input  logic               tx_done,
   output logic               swap_ack,
   output logic               disp_bank,
   output logic               rd_en,
   output logic [PIXEL_W-1:0] rd_addr,
   output logic               load_sreg,
   output logic               transmit_pixel,
   output logic [FRAME_W-1:0] frame,
   output logic               frame_done,
   output logic               busy,
   output logic               tx_err
);

   localparam int LAT_W = $clog2(LATCH_CYCLES + 1);
   localparam int PER_W = $clog2(FRAME_PERIOD + 1);

   if ((2**PIXEL_W) < NUM_PIXELS || LATCH_CYCLES < 1 || FRAME_PERIOD < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("led_frame_scheduler: invalid parameter set");
   end

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_SEND, S_LATCH, S_WAIT} state_t;

   state_t             r_state;
   state_t             w_state_next;
   logic [PIXEL_W-1:0] r_rd_addr;
   logic [FRAME_W-1:0] r_frame;
   logic [PER_W-1:0]   r_period;
   logic [LAT_W-1:0]   r_latch_cnt;
   logic               r_bank;
   logic               r_pending;
   logic               r_swap_ack;
   logic               w_start;
   logic               w_last_pixel;
   logic               w_latch_end;
   logic               w_period_ok;
   logic               w_timeout;

   assign w_last_pixel = (r_rd_addr == PIXEL_W'(NUM_PIXELS - 1));
   assign w_latch_end  = (r_latch_cnt == LAT_W'(LATCH_CYCLES - 1));
   assign w_period_ok  = (r_period >= PER_W'(FRAME_PERIOD - 1));
   assign w_start      = enable && ((r_state == S_IDLE) || ((r_state == S_WAIT) && w_period_ok));

   always_ff @(negedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (w_start) w_state_next = S_FETCH;
         S_FETCH: w_state_next = S_LOAD;
         S_LOAD:  w_state_next = S_SEND;
         S_SEND: begin
            if (tx_done)        w_state_next = w_last_pixel ? S_LATCH : S_FETCH;
            else if (w_timeout) w_state_next = S_LATCH;
         end
         S_LATCH: if (w_latch_end) w_state_next = S_WAIT;
         S_WAIT:  if (w_period_ok) w_state_next = enable ? S_FETCH : S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      rd_en          = 1'b0;
      load_sreg      = 1'b0;
      transmit_pixel = 1'b0;
      frame_done     = 1'b0;
      busy           = (r_state != S_IDLE);
      case (r_state)
         S_FETCH: rd_en          = 1'b1;
         S_LOAD:  load_sreg      = 1'b1;
         S_SEND:  transmit_pixel = 1'b1;
         S_LATCH: frame_done     = w_latch_end;
         default: ;
      endcase
   end

   // Period counter restarts at each frame start and saturates so a long stall never wraps it.
   always_ff @(negedge clk) begin
      if (rst) begin
         r_rd_addr   <= '0;
         r_frame     <= '0;
         r_period    <= '0;
         r_latch_cnt <= '0;
         r_bank      <= 1'b0;
         r_pending   <= 1'b0;
         r_swap_ack  <= 1'b0;
      end else begin
         if (w_start) begin
            r_rd_addr <= '0;
            r_period  <= '0;
         end else begin
            if (r_period != {PER_W{1'b1}}) r_period <= r_period + 1'b1;
            if ((r_state == S_SEND) && tx_done && !w_last_pixel) r_rd_addr <= r_rd_addr + 1'b1;
         end

         if (r_state == S_LATCH) r_latch_cnt <= r_latch_cnt + 1'b1;
         else                    r_latch_cnt <= '0;

         if ((r_state == S_LATCH) && w_latch_end) r_frame <= r_frame + 1'b1;

         // A request arriving in the same cycle as an applied swap is absorbed into it.
         r_swap_ack <= w_start && r_pending;
         if (w_start && r_pending) begin
            r_bank    <= ~r_bank;
            r_pending <= 1'b0;
         end else if (swap_req) begin
            r_pending <= 1'b1;
         end
      end
   end

`ifdef LED_TX_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] r_send_cnt;
   logic            r_tx_err;

   always_ff @(negedge clk) begin
      if (rst) begin
         r_send_cnt <= '0;
         r_tx_err   <= 1'b0;
      end else begin
         if (r_state == S_SEND) r_send_cnt <= r_send_cnt + 1'b1;
         else                   r_send_cnt <= '0;
         if (w_timeout) r_tx_err <= 1'b1;
      end
   end

   assign w_timeout = (r_state == S_SEND) && !tx_done && (r_send_cnt == TO_W'(TIMEOUT_CYCLES - 1));
   assign tx_err    = r_tx_err;
`else
   assign w_timeout = 1'b0;
   assign tx_err    = 1'b0;
`endif

   assign rd_addr   = r_rd_addr;
   assign frame     = r_frame;
   assign disp_bank = r_bank;
   assign swap_ack  = r_swap_ack;

endmodule
